// File: rtl/dmux_stream.sv
// Registered 1-to-NUM_OUT stream demultiplexer with valid/ready on every side.
// Supports unicast routing by in_sel and broadcast to all channels.
module dmux_stream #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic               sel_err
);

    localparam int unsigned CMP_W = SEL_W + 1;

    logic [NUM_OUT-1:0] pend_q;
    logic [WIDTH-1:0]   data_q;
    logic               err_q;

    logic [NUM_OUT-1:0] accepted_c;
    logic [NUM_OUT-1:0] remain_c;
    logic               done_c;
    logic               fire_c;
    logic               sel_ok_c;
    logic [NUM_OUT-1:0] onehot_c;

    logic [NUM_OUT-1:0] pend_d;
    logic [WIDTH-1:0]   data_d;
    logic               err_d;

    // Channel completion and drain detection; in_ready follows out_ready combinationally
    always_comb begin
        accepted_c = pend_q & out_ready;
        remain_c   = pend_q & ~accepted_c;
        done_c     = (remain_c == '0);
        fire_c     = in_valid & done_c;
        sel_ok_c   = ({1'b0, in_sel} < CMP_W'(NUM_OUT));
        onehot_c   = NUM_OUT'(1) << in_sel;
    end

    // Next-state: load on fire (bad select is consumed but delivers nothing), else clear accepted bits
    always_comb begin
        pend_d = remain_c;
        data_d = data_q;
        err_d  = 1'b0;
        if (fire_c) begin
            if (in_bcast) begin
                pend_d = '1;
                data_d = in_data;
            end else if (sel_ok_c) begin
                pend_d = onehot_c;
                data_d = in_data;
            end else begin
                pend_d = '0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign in_ready  = done_c;
    assign out_valid = pend_q;
    assign out_data  = data_q;
    assign busy      = |pend_q;
    assign sel_err   = err_q;

endmodule
